// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, 6502 address map and select decode.
package bus_pkg;

   typedef enum logic [1:0] {RST, PH1, PH2, STRETCH} bus_state_e;

   // Bit positions inside the one-hot select vector {ram, acia, via, rom}
   localparam int SEL_RAM  = 3;
   localparam int SEL_ACIA = 2;
   localparam int SEL_VIA  = 1;
   localparam int SEL_ROM  = 0;

   localparam logic [15:0] RAM_BASE  = 16'h0000;
   localparam logic [15:0] RAM_MASK  = 16'h8000;
   localparam logic [15:0] ACIA_BASE = 16'h8000;
   localparam logic [15:0] ACIA_SIZE = 16'd4;
   localparam logic [15:0] VIA_BASE  = 16'h8010;
   localparam logic [15:0] VIA_SIZE  = 16'd16;
   localparam logic [15:0] ROM_BASE  = 16'hC000;

   function automatic logic [3:0] bus_decode(input logic [15:0] addr);
      logic [3:0] sel;
      sel           = '0;
      sel[SEL_RAM]  = (addr & RAM_MASK) == RAM_BASE;
      sel[SEL_ACIA] = (addr >= ACIA_BASE) && (addr < ACIA_BASE + ACIA_SIZE);
      sel[SEL_VIA]  = (addr >= VIA_BASE) && (addr < VIA_BASE + VIA_SIZE);
      sel[SEL_ROM]  = addr >= ROM_BASE;
      return sel;
   endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// rtl/bus_cycle_ctrl_if.sv - CPU-side bus signals between the 6502 core and the cycle sequencer.
interface bus_cycle_ctrl_if;
   logic [15:0] cpu_addr;
   logic        cpu_rwb;
   logic        cpu_clken;
   logic        phi2;
   logic        cpu_reset;
   logic        ram_cs;
   logic        acia_cs;
   logic        via_cs;
   logic        rom_cs;
   logic        wr_stb;

   modport master (
      output cpu_addr, cpu_rwb,
      input  cpu_clken, phi2, cpu_reset, ram_cs, acia_cs, via_cs, rom_cs, wr_stb
   );

   modport slave (
      input  cpu_addr, cpu_rwb,
      output cpu_clken, phi2, cpu_reset, ram_cs, acia_cs, via_cs, rom_cs, wr_stb
   );
endinterface

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational CPU address to one-hot {ram, acia, via, rom} select.
module bus_addr_decode
   import bus_pkg::*;
(
   input  logic [15:0] addr,
   output logic [3:0]  sel
);
   assign sel = bus_decode(addr);
endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 6502 bus cycle sequencer: phi2/clken generation, reset hold,
// registered chip selects and phi2 stretch for ACIA/VIA cycles.
module bus_cycle_ctrl
   import bus_pkg::*;
#(
   parameter int CLKEN_BITS   = 3,
   parameter int IO_WAIT      = 2,
   parameter int RESET_CYCLES = 4
)(
   input  logic           clk,
   input  logic           resb,
   bus_cycle_ctrl_if.slave bus
);
   localparam int              HALF       = 1 << (CLKEN_BITS - 1);
   localparam int              CW         = (CLKEN_BITS > 1) ? CLKEN_BITS - 1 : 1;
   localparam logic [CW-1:0]   HALF_M1    = CW'(HALF - 1);
   localparam logic [3:0]      WAIT_INIT  = (IO_WAIT > 0) ? 4'(IO_WAIT - 1) : 4'd0;
   localparam logic [7:0]      RC_M1      = 8'(RESET_CYCLES - 1);
   localparam bit              STRETCH_EN = (IO_WAIT > 0);

   bus_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    wait_q, wait_d;
   logic [7:0]    rst_cnt_q, rst_cnt_d;
   logic          phi2_q, phi2_d;
   logic          clken_q, clken_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          rwb_q, rwb_d;
   logic [3:0]    sel_q, sel_d;
   logic [3:0]    dec_sel;
   logic          half_end;
   logic          io_d;

   bus_addr_decode u_decode (
      .addr (bus.cpu_addr),
      .sel  (dec_sel)
   );

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         state_q     <= RST;
         cnt_q       <= '0;
         wait_q      <= '0;
         rst_cnt_q   <= '0;
         phi2_q      <= 1'b0;
         clken_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
         rwb_q       <= 1'b1;
         sel_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         rst_cnt_q   <= rst_cnt_d;
         phi2_q      <= phi2_d;
         clken_q     <= clken_d;
         cpu_reset_q <= cpu_reset_d;
         rwb_q       <= rwb_d;
         sel_q       <= sel_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      wait_d      = wait_q;
      rst_cnt_d   = rst_cnt_q;
      phi2_d      = phi2_q;
      cpu_reset_d = cpu_reset_q;
      rwb_d       = rwb_q;
      sel_d       = sel_q;
      half_end    = (cnt_q == HALF_M1);

      case (state_q)
         RST: begin
            if (half_end) begin
               cnt_d  = '0;
               phi2_d = !phi2_q;
               // End of the phi2-high half is the end of a CPU cycle in reset
               if (phi2_q) begin
                  rst_cnt_d = rst_cnt_q + 8'd1;
                  if (rst_cnt_q == RC_M1) begin
                     state_d     = PH1;
                     cpu_reset_d = 1'b0;
                     rst_cnt_d   = '0;
                  end
               end
            end
         end
         PH1: begin
            if (half_end) begin
               cnt_d   = '0;
               phi2_d  = 1'b1;
               state_d = PH2;
               sel_d   = dec_sel;
               rwb_d   = bus.cpu_rwb;
            end
         end
         PH2: begin
            if (half_end) begin
               cnt_d = '0;
               if (STRETCH_EN && (sel_q[SEL_ACIA] || sel_q[SEL_VIA])) begin
                  state_d = STRETCH;
                  wait_d  = WAIT_INIT;
               end else begin
                  state_d = PH1;
                  phi2_d  = 1'b0;
                  sel_d   = '0;
               end
            end
         end
         STRETCH: begin
            cnt_d = cnt_q;
            if (wait_q == 4'd0) begin
               state_d = PH1;
               phi2_d  = 1'b0;
               sel_d   = '0;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         default: state_d = RST;
      endcase

      // cpu_clken is registered, so it is raised when the next clk is the cycle's last
      io_d    = sel_d[SEL_ACIA] || sel_d[SEL_VIA];
      clken_d = ((((state_d == PH2) && !(io_d && STRETCH_EN)) || ((state_d == RST) && phi2_d))
                 && (cnt_d == HALF_M1))
                || ((state_d == STRETCH) && (wait_d == 4'd0));
   end

   assign bus.cpu_clken = clken_q;
   assign bus.phi2      = phi2_q;
   assign bus.cpu_reset = cpu_reset_q;
   assign bus.ram_cs    = sel_q[SEL_RAM];
   assign bus.acia_cs   = sel_q[SEL_ACIA];
   assign bus.via_cs    = sel_q[SEL_VIA];
   assign bus.rom_cs    = sel_q[SEL_ROM];
   assign bus.wr_stb    = !rwb_q && phi2_q && (|sel_q);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl against a per-cycle waveform model.
module tb_bus_cycle_ctrl;
   localparam int CLKEN_BITS   = 3;
   localparam int IO_WAIT      = 2;
   localparam int RESET_CYCLES = 4;
   localparam int HALF         = 1 << (CLKEN_BITS - 1);

   logic clk  = 1'b0;
   logic resb = 1'b1;
   int   total = 0;
   int   bad   = 0;

   bus_cycle_ctrl_if bus ();

   bus_cycle_ctrl #(
      .CLKEN_BITS   (CLKEN_BITS),
      .IO_WAIT      (IO_WAIT),
      .RESET_CYCLES (RESET_CYCLES)
   ) dut (
      .clk  (clk),
      .resb (resb),
      .bus  (bus)
   );

   always #10 clk = ~clk;

   // {ram, acia, via, rom} from the memory map as address ranges
   function automatic logic [3:0] ref_decode(input logic [15:0] a);
      if (a <= 16'h7FFF)                       return 4'b1000;
      else if (a >= 16'h8000 && a <= 16'h8003) return 4'b0100;
      else if (a >= 16'h8010 && a <= 16'h801F) return 4'b0010;
      else if (a >= 16'hC000)                  return 4'b0001;
      else                                     return 4'b0000;
   endfunction

   function automatic logic [7:0] obs();
      return {bus.phi2, bus.cpu_clken, bus.cpu_reset, bus.ram_cs, bus.acia_cs,
              bus.via_cs, bus.rom_cs, bus.wr_stb};
   endfunction

   // Checks one whole CPU cycle clk by clk; optionally changes the address mid-phi2
   task automatic run_cycle(input logic [15:0] addr, input logic rwb, input bit chg,
                            input logic [15:0] alt_addr, input string name);
      logic [3:0] sel;
      logic [7:0] exp, got;
      int         len, clkens, sel_clks;
      sel      = ref_decode(addr);
      len      = 2 * HALF + ((sel[2] || sel[1]) ? IO_WAIT : 0);
      clkens   = 0;
      sel_clks = 0;
      bus.cpu_addr = addr;
      bus.cpu_rwb  = rwb;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         got = obs();
         exp = {k >= HALF, k == len - 1, 1'b0, (k >= HALF) ? sel : 4'b0000,
                (k >= HALF) && !rwb && (sel != 4'b0000)};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL %s addr=%h clk%0d: got %b want %b (phi2 clken rst ram acia via rom wr)",
                     name, addr, k, got, exp);
         end
         if (got[6]) clkens++;
         if (|got[4:1]) sel_clks++;
         if (chg && k == HALF + 1) bus.cpu_addr = alt_addr;
      end
      total++;
      if (clkens != 1 || sel_clks != ((sel != 4'b0000) ? len - HALF : 0)) begin
         bad++;
         $display("FAIL %s_counts addr=%h: clken=%0d sel_clks=%0d want clken=1 sel_clks=%0d",
                  name, addr, clkens, sel_clks, (sel != 4'b0000) ? len - HALF : 0);
      end
   endtask

   task automatic check_reset_hold(input string name);
      logic [7:0] exp, got;
      for (int c = 0; c < RESET_CYCLES; c++) begin
         for (int k = 0; k < 2 * HALF; k++) begin
            @(negedge clk);
            got = obs();
            exp = {k >= HALF, k == 2 * HALF - 1, 1'b1, 4'b0000, 1'b0};
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL %s cycle%0d clk%0d: got %b want %b", name, c, k, got, exp);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] got;
      bus.cpu_addr = 16'h0000;
      bus.cpu_rwb  = 1'b1;
      #1 resb = 1'b0;
      repeat (10) begin
         @(negedge clk);
         got = obs();
         total++;
         if (got !== 8'b0010_0000) begin
            bad++;
            $display("FAIL reset_state: got %b want 00100000", got);
         end
      end
      @(posedge clk);
      #1 resb = 1'b1;
      check_reset_hold("reset_hold");
   endtask

   task automatic test_ram_read();
      run_cycle(16'h3400, 1'b1, 1'b0, 16'h0000, "ram_read");
   endtask

   task automatic test_acia_write();
      run_cycle(16'h8000, 1'b0, 1'b0, 16'h0000, "acia_write");
   endtask

   task automatic test_decode_bounds();
      logic [15:0] addrs [9];
      addrs = '{16'h7FFF, 16'h8003, 16'h8004, 16'h8010, 16'h801F,
                16'h8020, 16'hBFFF, 16'hC000, 16'hFFFC};
      foreach (addrs[i]) run_cycle(addrs[i], 1'b1, 1'b0, 16'h0000, "decode_bound");
   endtask

   task automatic test_addr_change();
      run_cycle(16'h8000, 1'b0, 1'b1, 16'h0000, "addr_change");
   endtask

   task automatic test_back_to_back();
      logic [15:0] a;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 4))
            0:       a = 16'($urandom);
            1:       a = 16'h8000 + 16'($urandom_range(0, 47));
            2:       a = 16'h7FF8 + 16'($urandom_range(0, 15));
            3:       a = 16'hBFF8 + 16'($urandom_range(0, 15));
            default: a = 16'($urandom_range(0, 16'h7FFF));
         endcase
         run_cycle(a, 1'($urandom_range(0, 1)), 1'b0, 16'h0000, "back_to_back");
      end
   endtask

   task automatic test_reset_in_stretch();
      logic [7:0] exp, got;
      bus.cpu_addr = 16'h8015;
      bus.cpu_rwb  = 1'b0;
      for (int k = 0; k <= 2 * HALF; k++) begin
         @(negedge clk);
         got = obs();
         exp = {k >= HALF, 1'b0, 1'b0, 4'b0000 | ((k >= HALF) ? 4'b0010 : 4'b0000), k >= HALF};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL stretch_pre clk%0d: got %b want %b", k, got, exp);
         end
      end
      @(posedge clk);
      resb = 1'b0;
      #1;
      got = obs();
      total++;
      if (got !== 8'b0010_0000) begin
         bad++;
         $display("FAIL stretch_reset_instant: got %b want 00100000", got);
      end
      repeat (3) begin
         @(negedge clk);
         got = obs();
         total++;
         if (got !== 8'b0010_0000) begin
            bad++;
            $display("FAIL stretch_reset_held: got %b want 00100000", got);
         end
      end
      @(posedge clk);
      #1 resb = 1'b1;
      check_reset_hold("stretch_reset_hold");
      run_cycle(16'h1234, 1'b0, 1'b0, 16'h0000, "after_reset_write");
   endtask

   initial begin
      test_reset();
      test_ram_read();
      test_acia_write();
      test_decode_bounds();
      test_addr_change();
      test_back_to_back();
      test_reset_in_stretch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Sequences the external 6502 bus cycle for the top-level system.
- Divides the system clock into the CPU clock-enable and the phi2 waveform.
- Holds the CPU in reset after power-up or an external reset.
- Decodes the CPU address into RAM/ROM/ACIA/VIA selects.
- Stretches phi2-high for I/O cycles so the slower ACIA/VIA peripherals meet their access times.
- Sits between the CPU core and the memory/peripheral instances inside top.

Parameters:
CLKEN_BITS, 3, CPU cycle length = 2**CLKEN_BITS clk periods; phi1 and phi2 are each half of it.
IO_WAIT, 2, extra clk periods phi2 is held high on ACIA/VIA cycles (0..15).
RESET_CYCLES, 4, CPU cycles the CPU reset is held after resb deasserts (1..255).

Ports:
clk  in  1  system clock (50 MHz)
resb  in  1  reset, asynchronous, active-low
cpu_addr  in  16  CPU address, stable from mid-phi1
cpu_rwb  in  1  CPU read(1)/write(0)
cpu_clken  out  1  one-clk pulse on the last clk of each CPU cycle; CPU advances on it
phi2  out  1  external phi2 (low = phi1, high = phi2)
cpu_reset  out  1  active-high reset to the CPU core
ram_cs  out  1  select, $0000-$7FFF
acia_cs  out  1  select, $8000-$8003
via_cs  out  1  select, $8010-$801F
rom_cs  out  1  select, $C000-$FFFF
wr_stb  out  1  write strobe: cpu_rwb=0 and phi2 high and any select

Behaviour:
- Reset (resb=0, asynchronous):
  - State is RST; all counters are 0.
  - Outputs: phi2=0, cpu_clken=0, cpu_reset=1, all selects 0, wr_stb=0.
- States: RST, PH1, PH2, STRETCH. HALF = 2**(CLKEN_BITS-1).
- RST:
  - After resb rises, the phase counter runs exactly as in PH1/PH2 and phi2 toggles normally.
  - cpu_clken pulses at each cycle end; the I/O stretch is never applied in RST.
  - cpu_reset stays 1 for the first RESET_CYCLES cpu_clken pulses.
  - cpu_reset drops to 0 on the clk after the RESET_CYCLES-th pulse; state becomes PH1.
- PH1: phi2=0 for HALF clks. On the last one, register the decode of cpu_addr into the selects; state becomes PH2.
- PH2: phi2=1 for HALF clks. Selects hold their registered values. On the last clk:
  - If (acia_cs|via_cs) and IO_WAIT>0: go to STRETCH with wait counter=IO_WAIT; cpu_clken is not asserted.
  - Otherwise: assert cpu_clken for 1 clk, clear the selects, go to PH1.
- STRETCH:
  - phi2 stays 1 and the selects hold.
  - The wait counter decrements each clk.
  - On the clk where the counter reaches 0: assert cpu_clken, clear the selects, go to PH1.
- Cycle lengths:
  - Normal cycle: 2*HALF clks.
  - I/O cycle: 2*HALF+IO_WAIT clks.
  - There is exactly one cpu_clken per CPU cycle.
- Decode:
  - Fully combinational from cpu_addr; registered only at the PH1→PH2 boundary.
  - Unmapped ranges ($8004-$800F, $8020-$BFFF) assert no select. Those cycles complete at normal length; reads return bus float.
  - At most one select is ever high.
- wr_stb: combinational from registered state only (glitch-free).
- Timing: cpu_clken, phi2 and the selects are registered outputs.
- resb asserted mid-cycle (including STRETCH): immediate return to RST. No partial cpu_clken; cpu_reset=1 and wr_stb=0 in the same instant.
- cpu_addr changing during PH2/STRETCH has no effect on the selects.

Decomposition:
- Shared package bus_pkg:
  - State enum {RST, PH1, PH2, STRETCH}.
  - Address-map constants: RAM_BASE/MASK, ACIA_BASE=$8000/size 4, VIA_BASE=$8010/size 16, ROM_BASE=$C000.
  - A decode function returning a one-hot select vector.
- One natural sub-module, bus_addr_decode: combinational, cpu_addr → one-hot {ram, acia, via, rom}. The sequencer registers its output.

Test Plan:
- Reset hold: resb low 10 clks, then high, defaults → cpu_reset=1 through 4 cpu_clken pulses, 0 on the next clk; pulses spaced 8 clks; phi2 low 4 clks / high 4 clks.
- RAM read at $3400 → ram_cs high for exactly 4 clks (phi2 high); cpu_clken on clk 8; wr_stb=0.
- ACIA write to $8000, IO_WAIT=2 → acia_cs and wr_stb high for 6 clks; phi2 high 6 clks; cycle length 10 clks; exactly one cpu_clken.
- Decode boundaries: $7FFF→ram_cs, $8003→acia_cs, $8004→none, $8010→via_cs, $801F→via_cs, $8020→none, $BFFF→none, $C000→rom_cs, $FFFC→rom_cs. Each checked one-hot; the none cases have normal 8-clk length.
- resb pulsed low on the 2nd STRETCH clk of a VIA access → same-instant phi2=0, via_cs=0, wr_stb=0, cpu_reset=1; no cpu_clken emitted; full RESET_CYCLES hold repeats.
- Address change mid-PH2 from $8000 to $0000 → acia_cs stays high; cycle still stretched to 10 clks.
